// File: rtl/entrada_teclado_if.sv
// Core-facing switch-input bus: active-low enter strobe plus the latched switch word.
// No backpressure; the core samples ent on its own divided clock.
interface entrada_teclado_if #(
  parameter int WIDTH = 16
);
  logic             ent;
  logic [WIDTH-1:0] sw_out;

  modport master (output ent, output sw_out);
  modport slave  (input ent, input sw_out);
endinterface

// File: rtl/entrada_teclado.sv
// Debounces the enter key, latches the switch word and emits one ent low/high strobe per press.
// Latency: ent falls DEB_CYCLES+2 clk after key_n goes low; no backpressure, a held key is ignored.
module entrada_teclado #(
  parameter int WIDTH       = 16,
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_n,
  input  logic [WIDTH-1:0]        sw_in,
  entrada_teclado_if.master       core,
  output logic                    busy,
  output logic [7:0]              press_count
);

  localparam int CNT_MAX = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    ASSERT,
    GAP,
    WAIT_REL
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             key_m;
  logic             key_s;
  logic             ent_q;
  logic [WIDTH-1:0] sw_q;

  assign core.ent    = ent_q;
  assign core.sw_out = sw_q;

  // Synchroniser resets to "released" so a key held through reset still needs a full debounce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ent_q       <= 1'b1;
      sw_q        <= '0;
      press_count <= 8'd0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DEB_PRESS: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            sw_q        <= sw_in;
            press_count <= press_count + 8'd1;
            ent_q       <= 1'b0;
            state       <= ASSERT;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            ent_q <= 1'b1;
            state <= GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // High phase is held a full core period so the core's release detector sees it.
        GAP: begin
          if (cnt == HOLD_LAST) begin
            state <= WAIT_REL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!key_s) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          ent_q <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entrada_teclado.sv
// Scoreboard bench for entrada_teclado with short debounce/hold so every phase is exercised.
module tb_entrada_teclado;
  localparam int W    = 16;
  localparam int DEB  = 4;
  localparam int HOLD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_n;
  logic [W-1:0]  sw_in;
  logic          busy;
  logic [7:0]    press_count;

  entrada_teclado_if #(.WIDTH(W)) core_if ();

  entrada_teclado #(
    .WIDTH      (W),
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .sw_in      (sw_in),
    .core       (core_if),
    .busy       (busy),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sw;
    logic [7:0]   cnt;
    int           fall;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         fall_cyc = 0;
  int         mark = 0;
  logic       prev_ent = 1'b1;
  bit         abort_pulse = 1'b0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ent(input logic v, input string tag);
    int n = 0;
    while (core_if.ent !== v && n < 100) begin
      tick();
      n++;
    end
    check(tag, {31'd0, core_if.ent}, {31'd0, v});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic press(input logic [W-1:0] sw);
    sw_in = sw;
    exp_cnt++;
    sb.push_back('{sw, exp_cnt, -1});
    key_n = 1'b0;
    wait_ent(1'b0, "press_fall");
    wait_ent(1'b1, "press_rise");
    key_n = 1'b1;
    wait_idle("press_idle");
  endtask

  // Pulse monitor: pops the scoreboard on each ent fall, checks pulse width on each rise.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #3;
    if (prev_ent === 1'b1 && core_if.ent === 1'b0) begin
      pulses++;
      fall_cyc = cyc;
      check("pulse_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sw_at_fall", {16'd0, core_if.sw_out}, {16'd0, mon_e.sw});
        check("count_at_fall", {24'd0, press_count}, {24'd0, mon_e.cnt});
        if (mon_e.fall >= 0) check("fall_time", cyc, mon_e.fall);
      end
    end else if (prev_ent === 1'b0 && core_if.ent === 1'b1) begin
      if (abort_pulse) abort_pulse = 1'b0;
      else check("pulse_len", cyc - fall_cyc, HOLD);
    end
    if (core_if.ent === 1'b0) check("busy_when_low", {31'd0, busy}, 32'd1);
    prev_ent = core_if.ent;
  end

  initial begin
    reset = 1'b0;
    key_n = 1'b1;
    sw_in = '0;
    tick();
    tick();
    check("rst_ent", {31'd0, core_if.ent}, 32'd1);
    check("rst_sw", {16'd0, core_if.sw_out}, 32'd0);
    check("rst_cnt", {24'd0, press_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Idle with key released
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ent", {31'd0, core_if.ent}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_sw", {16'd0, core_if.sw_out}, 32'd0);
      check("idle_cnt", {24'd0, press_count}, 32'd0);
    end

    // Clean press held 30 cycles: fall exactly DEB+2 edges after first sample
    sw_in = 16'hA5C3;
    exp_cnt = 8'd1;
    sb.push_back('{16'hA5C3, 8'd1, cyc + 1 + DEB + 2});
    key_n = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("t2_pulses", pulses, 1);
    check("t2_cnt", {24'd0, press_count}, 32'd1);
    check("t2_sw", {16'd0, core_if.sw_out}, 32'hA5C3);
    check("t2_held_busy", {31'd0, busy}, 32'd1);
    key_n = 1'b1;
    wait_idle("t2_idle");

    // Bounce one cycle shorter than the debounce window
    sw_in = 16'hFFFF;
    key_n = 1'b0;
    for (int i = 0; i < DEB - 1; i++) tick();
    key_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t3_pulses", pulses, 1);
    check("t3_cnt", {24'd0, press_count}, 32'd1);
    check("t3_sw", {16'd0, core_if.sw_out}, 32'hA5C3);
    check("t3_busy", {31'd0, busy}, 32'd0);

    // Bouncing key through ASSERT/GAP/WAIT_REL, sw_in changed during ASSERT
    sw_in = 16'hA5C3;
    exp_cnt++;
    sb.push_back('{16'hA5C3, exp_cnt, -1});
    key_n = 1'b0;
    wait_ent(1'b0, "t4_fall");
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) sw_in = 16'h1234;
      key_n = i[0] ? 1'b0 : 1'b1;
    end
    tick();
    key_n = 1'b1;
    for (int i = 0; i < DEB + 1; i++) tick();
    check("t4_still_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t4_rel_exit", {31'd0, busy}, 32'd0);
    check("t4_sw", {16'd0, core_if.sw_out}, 32'hA5C3);
    check("t4_pulses", pulses, 2);
    check("t4_cnt", {24'd0, press_count}, 32'd2);

    // 256 presses wrap the counter, the 257th reads 1
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) press(16'($urandom));
    check("t5_wrap", {24'd0, press_count}, 32'd0);
    press(16'h5A5A);
    check("t5_257", {24'd0, press_count}, 32'd1);

    // Reset on the second ASSERT cycle, key still held afterwards
    sw_in = 16'h0F0F;
    exp_cnt++;
    sb.push_back('{16'h0F0F, exp_cnt, -1});
    key_n = 1'b0;
    wait_ent(1'b0, "t6_fall");
    tick();
    abort_pulse = 1'b1;
    reset = 1'b0;
    #1;
    check("t6_async_ent", {31'd0, core_if.ent}, 32'd1);
    check("t6_sw", {16'd0, core_if.sw_out}, 32'd0);
    check("t6_cnt", {24'd0, press_count}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    mark = cyc;
    exp_cnt = 8'd1;
    sb.push_back('{16'h0F0F, 8'd1, mark + 1 + DEB + 2});
    for (int i = 0; i < DEB + 2; i++) begin
      tick();
      check("t6_redeb_ent", {31'd0, core_if.ent}, 32'd1);
    end
    wait_ent(1'b0, "t6_refall");
    wait_ent(1'b1, "t6_rerise");
    key_n = 1'b1;
    wait_idle("t6_idle");

    check("sb_empty", sb.size(), 32'd0);
    check("total_pulses", pulses, 2 + 257 + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/entrada_teclado.md
Name: entrada_teclado

Overview:
Producer side of the processor's switch-input handshake. Synchronises and debounces the raw active-low "enter" push-button on the fast board clock and latches the 16-bit switch word at a confirmed press. It then drives a clean active-low `ent` strobe toward the processor core, timed against the divided processor clock, so that the core's press-then-release detector always sees exactly one low phase followed by one high phase. Sits between the board pins (key, switches) and the core's `ent`/`switch` inputs.

Parameters:
WIDTH, 16, width of switch word.
DEB_CYCLES, 1000000, clk cycles key must be stable (20 ms at 50 MHz) to accept a press or a release.
HOLD_CYCLES, 25000000, clk cycles `ent` is held low, and then held high, per strobe; equals one full processor clock period.

Ports:
clk  in  1  fast board clock (50 MHz).
reset  in  1  asynchronous, active-low.
key_n  in  1  raw push-button, active-low, asynchronous, bouncing.
sw_in  in  WIDTH  raw switch bank.
ent  out  1  clean active-low strobe to the core.
sw_out  out  WIDTH  switch word latched at the confirmed press; feeds the core's switch input.
busy  out  1  high whenever state != IDLE.
press_count  out  8  number of accepted presses, modulo 256.

Behaviour:
- Reset (async, reset=0): state=IDLE; ent=1; sw_out=0; press_count=0; counter=0; both synchroniser flops=1. Release is applied synchronously at the next clk edge.
- Synchroniser: key_s is key_n after 2 flops (2-cycle delay). The FSM uses only key_s.
- Counter: a single counter, width clog2(max(DEB_CYCLES,HOLD_CYCLES)). It is cleared on every state change.
- States: IDLE, DEB_PRESS, ASSERT, GAP, WAIT_REL. All outputs are registered.
- IDLE: ent=1. If key_s=0, go to DEB_PRESS.
- DEB_PRESS:
  - If key_s=1 (bounce), return to IDLE without latching.
  - Else if counter==DEB_CYCLES-1: sw_out<=sw_in, press_count<=press_count+1 (wraps 255->0), ent<=0, go to ASSERT.
  - Else counter++.
- ASSERT: ent=0 for exactly HOLD_CYCLES clk cycles. key_n is ignored. When counter==HOLD_CYCLES-1: ent<=1, go to GAP.
- GAP: ent=1 for exactly HOLD_CYCLES cycles, which guarantees the core samples the high level. key_n is ignored. Then go to WAIT_REL.
- WAIT_REL:
  - If key_s=0, clear the counter and stay.
  - Else count; when counter==DEB_CYCLES-1, go to IDLE.
  - A held key therefore never produces a second strobe.
- Latency: if key_n is first sampled low at edge e0 and stays low, ent falls at edge e0+DEB_CYCLES+2. It then stays low for HOLD_CYCLES edges.
- sw_out changes only on entry to ASSERT. Its value is stable throughout ASSERT, GAP, WAIT_REL and the following IDLE. Changes on sw_in outside that entry edge have no effect.
- Exactly one ent low pulse per accepted press. ent is never low outside ASSERT.
- Reset mid-ASSERT: ent returns to 1 asynchronously and no further pulse is issued for that press. press_count and sw_out are cleared.
- DEB_CYCLES and HOLD_CYCLES must be >=1. With value 1, the state lasts exactly one cycle.

Test Plan (DEB_CYCLES=4, HOLD_CYCLES=3):
1. Reset, then hold key_n=1 for 20 cycles -> ent=1, busy=0, sw_out=0, press_count=0 throughout.
2. sw_in=16'hA5C3, key_n low at e0 and held 30 cycles -> ent=0 on edges e0+6..e0+8, then 1. sw_out=16'hA5C3 from e0+6. press_count=1. Only one pulse.
3. key_n low for 3 cycles then high (bounce shorter than debounce) -> no ent pulse, sw_out unchanged, press_count unchanged, busy returns to 0.
4. Valid press with key_n bouncing 1/0 during ASSERT and GAP, then released -> single 3-cycle low pulse. WAIT_REL exits 4 cycles after the last key_s=1 restart. sw_in changed to 16'h1234 during ASSERT -> sw_out stays 16'hA5C3.
5. 256 accepted presses from reset -> press_count wraps to 0. The 257th press -> press_count=1.
6. reset asserted on the second cycle of ASSERT -> ent=1 immediately (asynchronous), sw_out=0, state IDLE. After reset is released with key_n still low, a new full debounce is required before ent falls again.
